// File: rtl/imem_loader_responder.sv
// Instruction memory: 0-cycle combinational fetch; byte-stream boot loader packs bytes LE into words.
// Loader: 5 cycles/word (4 bytes + commit), ld_ready low during commit; busy forces NOP fetches.
module imem_loader_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [63:0]                    im_addr,
  output logic [31:0]                    im_dout,
  output logic                           im_fault,
  output logic                           imem_busy,
  input  logic                           ld_start,
  input  logic [7:0]                     ld_byte,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic                           ld_done,
  output logic [$clog2(DEPTH_WORDS):0]   ld_words,
  output logic                           ld_overflow
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] W_LAST = CW'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_FULL
  } state_t;

  state_t         r_state;
  logic [31:0]    r_shreg;
  logic [1:0]     r_byte_idx;
  logic [CW-1:0]  r_words;
  logic           r_ovf;
  logic           r_done_pend;
  logic           r_busy;
  logic           r_ready;
  logic [31:0]    r_mem [DEPTH_WORDS];

  logic [63:0]    w_off;
  logic [AW-1:0]  w_idx;
  logic [1:0]     w_off_unused;
  logic           w_below;
  logic           w_range;
  logic           w_misalign;
  logic           w_hs;
  logic           w_last_byte;

  // Fetch path: pure combinational decode of the byte address
  assign w_off        = im_addr - BASE_ADDR;
  assign w_idx        = w_off[AW+1:2];
  assign w_off_unused = w_off[1:0];
  assign w_below      = (im_addr < BASE_ADDR);
  assign w_range      = |w_off[63:AW+2];
  assign w_misalign   = (im_addr[1:0] != 2'b00);

  assign im_fault  = w_below | w_range | w_misalign;
  assign im_dout   = (im_fault || r_busy) ? NOP_WORD : r_mem[w_idx];

  assign imem_busy   = r_busy;
  assign ld_ready    = r_ready;
  assign ld_words    = r_words;
  assign ld_overflow = r_ovf;

  assign w_hs        = ld_valid & r_ready;
  assign w_last_byte = w_hs & (r_byte_idx == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_byte_idx  <= '0;
      r_words     <= '0;
      r_ovf       <= 1'b0;
      r_done_pend <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
    end else if (ld_start) begin
      // Start beats done and drops any pending commit
      r_state     <= S_LOAD;
      r_shreg     <= '0;
      r_byte_idx  <= '0;
      r_words     <= '0;
      r_ovf       <= 1'b0;
      r_done_pend <= 1'b0;
      r_busy      <= 1'b1;
      r_ready     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
        end
        S_LOAD: begin
          if (w_hs) begin
            r_shreg[{r_byte_idx, 3'b000} +: 8] <= ld_byte;
            r_byte_idx                         <= r_byte_idx + 2'd1;
          end
          if (w_last_byte || (ld_done && (w_hs || (r_byte_idx != 2'd0)))) begin
            r_state     <= S_COMMIT;
            r_ready     <= 1'b0;
            r_done_pend <= ld_done;
          end else if (ld_done) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        S_COMMIT: begin
          r_words     <= r_words + 1'b1;
          r_shreg     <= '0;
          r_byte_idx  <= '0;
          r_done_pend <= 1'b0;
          if (r_done_pend || ld_done) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_words == W_LAST) begin
            r_state <= S_FULL;
            r_ready <= 1'b1;
          end else begin
            r_state <= S_LOAD;
            r_ready <= 1'b1;
          end
        end
        S_FULL: begin
          if (w_hs) begin
            r_ovf <= 1'b1;
          end
          if (ld_done) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is never reset so boot contents survive a mid-load reset
  always_ff @(posedge clk) begin
    if (reset && (r_state == S_COMMIT) && !ld_start) begin
      r_mem[r_words[AW-1:0]] <= r_shreg;
    end
  end

endmodule

// File: tb/tb_imem_loader_responder.sv
// Bench for imem_loader_responder: table vectors, hand sequences and randomized loads vs a word-level model.
module tb_imem_loader_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic [63:0] im_addr;
  logic [31:0] im_dout;
  logic        im_fault, imem_busy, ld_start, ld_valid, ld_ready, ld_done, ld_overflow;
  logic [7:0]  ld_byte;
  logic [10:0] ld_words;

  logic [63:0] f_addr;
  logic [31:0] f_dout;
  logic        f_fault, f_busy, f_start, f_valid, f_ready, f_done, f_ovf;
  logic [7:0]  f_byte;
  logic [2:0]  f_words;

  imem_loader_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(64'h0), .NOP_WORD(32'h00000013)) dut (
    .clk(clk), .reset(reset), .im_addr(im_addr), .im_dout(im_dout), .im_fault(im_fault),
    .imem_busy(imem_busy), .ld_start(ld_start), .ld_byte(ld_byte), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_words(ld_words), .ld_overflow(ld_overflow)
  );

  imem_loader_responder #(.DEPTH_WORDS(4), .BASE_ADDR(64'h1000), .NOP_WORD(32'h00000013)) dut4 (
    .clk(clk), .reset(reset), .im_addr(f_addr), .im_dout(f_dout), .im_fault(f_fault),
    .imem_busy(f_busy), .ld_start(f_start), .ld_byte(f_byte), .ld_valid(f_valid),
    .ld_ready(f_ready), .ld_done(f_done), .ld_words(f_words), .ld_overflow(f_ovf)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  sbuf [64];
  logic [31:0] mdl_mem [1024];
  bit          mdl_known [1024];

  typedef struct {
    logic [63:0] addr;
    logic [31:0] dout;
    logic        fault;
  } rd_vec_t;
  rd_vec_t tbl [8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: byte k of the stream lands in word k/4, lane k%4; partial last word zero-padded
  task automatic model_apply(input int n);
    for (int w = 0; w < (n + 3) / 4; w++) begin
      logic [31:0] v;
      v = '0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < n) v = v | ({24'h0, sbuf[4*w+b]} << (8 * b));
      mdl_mem[w]   = v;
      mdl_known[w] = 1'b1;
    end
  endtask

  task automatic read_check(input logic [63:0] a);
    logic exp_fault;
    @(negedge clk);
    im_addr = a;
    #1;
    exp_fault = (a[1:0] != 2'b00) || ((a >> 2) >= 64'd1024);
    check("rd_fault", 64'(im_fault), 64'(exp_fault));
    if (exp_fault) check("rd_fault_nop", 64'(im_dout), 64'(NOP));
    else if (mdl_known[a[11:2]]) check("rd_data", 64'(im_dout), 64'(mdl_mem[a[11:2]]));
  endtask

  task automatic start_load();
    @(negedge clk);
    ld_start = 1'b1; ld_valid = 1'b0; ld_done = 1'b0;
    @(negedge clk);
    ld_start = 1'b0;
    check("start_busy", 64'(imem_busy), 64'd1);
    check("start_ready", 64'(ld_ready), 64'd1);
    check("start_words", 64'(ld_words), 64'd0);
    check("start_ovf", 64'(ld_overflow), 64'd0);
  endtask

  task automatic feed(input int n, input bit done_last);
    int i, cyc, budget;
    i = 0; cyc = 0; budget = 20 * n + 40;
    while (i < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      ld_done  = 1'b0;
      ld_byte  = sbuf[i];
      ld_valid = ($urandom_range(0, 3) != 0);
      if (i == n - 1 && done_last && ld_ready) begin
        ld_valid = 1'b1;
        ld_done  = 1'b1;
      end
      im_addr = 64'($urandom_range(0, 1023)) << 2;
      #1;
      check("busy_during_load", 64'(imem_busy), 64'd1);
      check("nop_during_load", 64'(im_dout), 64'(NOP));
      if (ld_valid && ld_ready) i++;
    end
    if (i < n) check("feed_timeout", 64'(i), 64'(n));
  endtask

  task automatic finish_load(input bit send_done);
    int k;
    @(negedge clk);
    ld_valid = 1'b0; ld_done = send_done;
    @(negedge clk);
    ld_done = 1'b0;
    k = 0;
    while (imem_busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("idle_after_done", 64'(imem_busy), 64'd0);
    check("ready_after_done", 64'(ld_ready), 64'd0);
  endtask

  task automatic verify_load(input int n);
    check("ld_words", 64'(ld_words), 64'((n + 3) / 4));
    check("ld_overflow_clr", 64'(ld_overflow), 64'd0);
    model_apply(n);
    for (int w = 0; w < (n + 3) / 4; w++) read_check(64'(w * 4));
  endtask

  task automatic rand_load(input int n, input bit dl);
    for (int i = 0; i < n; i++) sbuf[i] = 8'($urandom);
    start_load();
    feed(n, dl);
    finish_load(!dl);
    verify_load(n);
  endtask

  logic [63:0] pat;
  int          k, cyc, n;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; im_addr = '0; ld_start = 0; ld_byte = '0; ld_valid = 0; ld_done = 0;
    f_addr = '0; f_start = 0; f_byte = '0; f_valid = 0; f_done = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(imem_busy), 64'd0);
    check("rst_ready", 64'(ld_ready), 64'd0);
    check("rst_words", 64'(ld_words), 64'd0);
    check("rst_ovf", 64'(ld_overflow), 64'd0);
    check("rst_busy4", 64'(f_busy), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(imem_busy), 64'd0);

    // Reference stream 13 00 00 00 B3 00 21 00, then table-driven fetches
    pat = 64'h002100B3_00000013;
    for (int i = 0; i < 8; i++) sbuf[i] = pat[8*i +: 8];
    start_load();
    feed(8, 1'b0);
    finish_load(1'b1);
    check("ref_words", 64'(ld_words), 64'd2);
    model_apply(8);
    tbl[0] = '{64'h0,                  32'h00000013, 1'b0};
    tbl[1] = '{64'h4,                  32'h002100B3, 1'b0};
    tbl[2] = '{64'h2,                  NOP,          1'b1};
    tbl[3] = '{64'h1000,               NOP,          1'b1};
    tbl[4] = '{64'h1,                  NOP,          1'b1};
    tbl[5] = '{64'h7,                  NOP,          1'b1};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFC, NOP,         1'b1};
    tbl[7] = '{64'h1003,               NOP,          1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      im_addr = tbl[i].addr;
      #1;
      check("tbl_dout", 64'(im_dout), 64'(tbl[i].dout));
      check("tbl_fault", 64'(im_fault), 64'(tbl[i].fault));
    end

    // Partial word AA BB CC: zero-padded, word 1 retained
    sbuf[0] = 8'hAA; sbuf[1] = 8'hBB; sbuf[2] = 8'hCC;
    start_load();
    feed(3, 1'b0);
    finish_load(1'b1);
    check("abc_words", 64'(ld_words), 64'd1);
    @(negedge clk);
    im_addr = 64'h0;
    #1;
    check("abc_word0", 64'(im_dout), 64'h00CCBBAA);
    model_apply(3);
    read_check(64'h4);

    // Done coincident with the last byte (4th byte and partial cases)
    rand_load(8, 1'b1);
    rand_load(6, 1'b1);

    // Reset after 2 bytes of word 1: word 0 committed, word 1 keeps old contents
    for (int i = 0; i < 8; i++) sbuf[i] = 8'($urandom);
    start_load();
    feed(6, 1'b0);
    @(negedge clk);
    ld_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(imem_busy), 64'd0);
    check("midrst_ready", 64'(ld_ready), 64'd0);
    check("midrst_words", 64'(ld_words), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    model_apply(4);
    read_check(64'h0);
    read_check(64'h4);
    rand_load(12, 1'b0);

    // Restart in the middle of a load
    n = $urandom_range(5, 30);
    for (int i = 0; i < n; i++) sbuf[i] = 8'($urandom);
    start_load();
    feed(5, 1'b0);
    start_load();
    feed(n, 1'b0);
    finish_load(1'b1);
    verify_load(n);

    // Randomized loads and fetches
    for (int t = 0; t < 4; t++) rand_load($urandom_range(1, 40), 1'($urandom_range(0, 1)));
    for (int t = 0; t < 30; t++) begin
      if (t % 3 == 0) read_check({$urandom, $urandom});
      else read_check(64'($urandom_range(0, 8191)));
    end

    // Four-word instance: fill, overflow, sticky flag
    @(negedge clk);
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    k = 0; cyc = 0;
    while (k < 20 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      f_valid = 1'b1;
      f_byte  = 8'(k);
      if (f_ready) k++;
    end
    check("full_feed", 64'(k), 64'd20);
    @(negedge clk);
    f_valid = 1'b0;
    #1;
    check("full_words", 64'(f_words), 64'd4);
    check("full_ovf", 64'(f_ovf), 64'd1);
    check("full_busy", 64'(f_busy), 64'd1);
    check("full_ready", 64'(f_ready), 64'd1);
    f_done = 1'b1;
    @(negedge clk);
    f_done = 1'b0;
    check("full_done_busy", 64'(f_busy), 64'd0);
    check("full_done_ready", 64'(f_ready), 64'd0);
    check("full_ovf_sticky", 64'(f_ovf), 64'd1);
    check("full_done_words", 64'(f_words), 64'd4);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      f_addr = 64'h1000 + 64'(4 * w);
      #1;
      check("full_rd", 64'(f_dout), 64'({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}));
      check("full_rd_fault", 64'(f_fault), 64'd0);
    end
    @(negedge clk);
    f_addr = 64'hFFC;
    #1;
    check("below_base_fault", 64'(f_fault), 64'd1);
    check("below_base_nop", 64'(f_dout), 64'(NOP));
    @(negedge clk);
    f_addr = 64'h1010;
    #1;
    check("past_end_fault", 64'(f_fault), 64'd1);
    @(negedge clk);
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    check("restart_ovf_clr", 64'(f_ovf), 64'd0);
    check("restart_words_clr", 64'(f_words), 64'd0);
    f_done = 1'b1;
    @(negedge clk);
    f_done = 1'b0;
    check("empty_done_idle", 64'(f_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
